// File: rtl/misc_v_pkg.sv
// misc_v_pkg: opcodes, instruction field positions, control encodings and the
// decode table shared by the decode stage.
package misc_v_pkg;

    localparam int unsigned ILEN      = 16;
    localparam int unsigned REG_AW    = 3;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned OP_LSB    = 0;
    localparam int unsigned RD_LSB    = 3;
    localparam int unsigned RS1_LSB   = 6;
    localparam int unsigned RS2_LSB   = 9;
    localparam int unsigned IMM_LSB   = 9;
    localparam int unsigned IMM_W     = 7;
    localparam int unsigned JIMM_LSB  = 6;
    localparam int unsigned JIMM_W    = 10;
    localparam int unsigned FUNCT_LSB = 12;
    localparam int unsigned FUNCT_W   = 4;

    localparam logic [OP_W-1:0] OP_R     = 3'b000;
    localparam logic [OP_W-1:0] OP_I     = 3'b001;
    localparam logic [OP_W-1:0] OP_LOAD  = 3'b010;
    localparam logic [OP_W-1:0] OP_STORE = 3'b011;
    localparam logic [OP_W-1:0] OP_BEQ   = 3'b100;
    localparam logic [OP_W-1:0] OP_BNE   = 3'b101;
    localparam logic [OP_W-1:0] OP_JAL   = 3'b110;
    localparam logic [OP_W-1:0] OP_NOP   = 3'b111;

    localparam logic [2:0] ALUOP_NONE = 3'b000;
    localparam logic [2:0] ALUOP_ADD  = 3'b001;
    localparam logic [2:0] ALUOP_REG  = 3'b010;

    localparam logic [1:0] RS_MEM  = 2'b00;
    localparam logic [1:0] RS_ALU  = 2'b01;
    localparam logic [1:0] RS_LINK = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] reg_store;
    } ctrl_t;

    // Control bundle for an opcode; branches and 111 decode to all-zero.
    function automatic ctrl_t decode_ctrl(input logic [OP_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_REG;
                c.reg_store = RS_ALU;
            end
            OP_I: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
                c.reg_store = RS_ALU;
            end
            OP_LOAD: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
                c.mem_read  = 1'b1;
                c.reg_store = RS_MEM;
            end
            OP_STORE: begin
                c.alu_op    = ALUOP_ADD;
                c.mem_write = 1'b1;
            end
            OP_JAL: begin
                c.reg_write = 1'b1;
                c.alu_op    = ALUOP_NONE;
                c.reg_store = RS_LINK;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/misc_v_regfile.sv
// misc_v_regfile: 8 x XLEN register file, x0 hardwired to zero, three
// combinational read ports that see a same-cycle writeback (write-through).
module misc_v_regfile
    import misc_v_pkg::*;
#(
    parameter int unsigned XLEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    input  logic [REG_AW-1:0] raddr_c,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b,
    output logic [XLEN-1:0]   rdata_c
);
    localparam int unsigned NREGS = 8;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] addr);
        if (addr == '0) return '0;
        if (we && (waddr == addr)) return wdata;
        return regs_q[addr];
    endfunction

    // Next register contents: writes to x0 are dropped.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) regs_d[waddr] = wdata;
    end

    // Register storage, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports with write-through bypass.
    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
        rdata_c = read_port(raddr_c);
    end

endmodule

// File: rtl/decode_pipe_unit.sv
// decode_pipe_unit: decode stage with register file, load-use interlock and an
// ID/EX pipeline register. Branch/JAL resolution is built only when the macro
// DECODE_BRANCH_RESOLVE_EN is defined; otherwise new_pc and jump are tied to 0.
module decode_pipe_unit
    import misc_v_pkg::*;
#(
    parameter int unsigned XLEN      = 16,
    parameter int unsigned IMM_SCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [ILEN-1:0]   ir_in,
    input  logic              rf_write,
    input  logic [REG_AW-1:0] rf_waddr,
    input  logic [XLEN-1:0]   rf_wdata,
    input  logic              cmp_fwd_sel1,
    input  logic              cmp_fwd_sel2,
    input  logic [XLEN-1:0]   cmp_fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWrite,
    output logic              ALUSrc,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [2:0]        ALUOp,
    output logic [1:0]        RegStore,
    output logic [3:0]        funct,
    output logic [XLEN-1:0]   Arg1,
    output logic [XLEN-1:0]   Arg2,
    output logic [XLEN-1:0]   Arg3,
    output logic [XLEN-1:0]   Imm,
    output logic [REG_AW-1:0] Rs1,
    output logic [REG_AW-1:0] Rs2,
    output logic [REG_AW-1:0] Rd,
    output logic [XLEN-1:0]   OPCP2,
    output logic [XLEN-1:0]   new_pc,
    output logic              jump
);
    typedef struct packed {
        ctrl_t              ctrl;
        logic [FUNCT_W-1:0] funct;
        logic [XLEN-1:0]    arg1;
        logic [XLEN-1:0]    arg2;
        logic [XLEN-1:0]    arg3;
        logic [XLEN-1:0]    imm;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [XLEN-1:0]    opcp2;
    } idex_t;

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]   rs1_val, rs2_val, rd_val, imm_sext;
    logic              load_use_c, accept_c;
    logic              out_valid_q, out_valid_d;
    idex_t             idex_q, idex_d;

    assign op       = ir_in[OP_LSB +: OP_W];
    assign rd_idx   = ir_in[RD_LSB +: REG_AW];
    assign rs1_idx  = ir_in[RS1_LSB +: REG_AW];
    assign rs2_idx  = ir_in[RS2_LSB +: REG_AW];
    assign imm_sext = {{(XLEN-IMM_W){ir_in[IMM_LSB+IMM_W-1]}}, ir_in[IMM_LSB +: IMM_W]};

    misc_v_regfile #(.XLEN(XLEN)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_write),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs1_idx),
        .raddr_b (rs2_idx),
        .raddr_c (rd_idx),
        .rdata_a (rs1_val),
        .rdata_b (rs2_val),
        .rdata_c (rd_val)
    );

    // Interlock while the load in ID/EX writes a register the offered instruction reads.
    always_comb begin
        load_use_c = 1'b0;
        if (out_valid_q && idex_q.ctrl.mem_read && (idex_q.rd != '0)) begin
            load_use_c = (idex_q.rd == rs1_idx) || (idex_q.rd == rs2_idx) ||
                         (((op == OP_STORE) || (op == OP_BEQ) || (op == OP_BNE)) &&
                          (idex_q.rd == rd_idx));
        end
    end

    assign in_ready = (~out_valid_q | out_ready) & ~load_use_c & ~flush & ~reset;
    assign accept_c = in_valid & in_ready;

    // ID/EX next state: flush clears, accept loads, consumption empties, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        idex_d      = idex_q;
        if (flush) begin
            out_valid_d = 1'b0;
            idex_d      = '0;
        end else if (accept_c) begin
            out_valid_d  = 1'b1;
            idex_d.ctrl  = decode_ctrl(op);
            idex_d.funct = ir_in[FUNCT_LSB +: FUNCT_W];
            idex_d.arg1  = rs1_val;
            idex_d.arg2  = rs2_val;
            idex_d.arg3  = rd_val;
            idex_d.imm   = imm_sext;
            idex_d.rs1   = rs1_idx;
            idex_d.rs2   = rs2_idx;
            idex_d.rd    = rd_idx;
            idex_d.opcp2 = pc_in + XLEN'(2);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            idex_d      = '0;
        end
    end

    // ID/EX register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            idex_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            idex_q      <= idex_d;
        end
    end

    assign out_valid = out_valid_q;
    assign RegWrite  = idex_q.ctrl.reg_write;
    assign ALUSrc    = idex_q.ctrl.alu_src;
    assign ALUOp     = idex_q.ctrl.alu_op;
    assign MemWrite  = idex_q.ctrl.mem_write;
    assign MemRead   = idex_q.ctrl.mem_read;
    assign RegStore  = idex_q.ctrl.reg_store;
    assign funct     = idex_q.funct;
    assign Arg1      = idex_q.arg1;
    assign Arg2      = idex_q.arg2;
    assign Arg3      = idex_q.arg3;
    assign Imm       = idex_q.imm;
    assign Rs1       = idex_q.rs1;
    assign Rs2       = idex_q.rs2;
    assign Rd        = idex_q.rd;
    assign OPCP2     = idex_q.opcp2;

`ifdef DECODE_BRANCH_RESOLVE_EN
    logic [XLEN-1:0] cmp_a, cmp_b, br_off, jal_off;
    logic            taken_c;

    assign cmp_a   = cmp_fwd_sel1 ? cmp_fwd_data : rs1_val;
    assign cmp_b   = cmp_fwd_sel2 ? cmp_fwd_data : rd_val;
    assign br_off  = imm_sext << IMM_SCALE;
    assign jal_off = {{(XLEN-JIMM_W){ir_in[ILEN-1]}}, ir_in[JIMM_LSB +: JIMM_W]} << IMM_SCALE;

    // Redirect target and branch condition for the offered instruction.
    always_comb begin
        new_pc  = '0;
        taken_c = 1'b0;
        case (op)
            OP_BEQ: begin
                new_pc  = pc_in + br_off;
                taken_c = (cmp_a == cmp_b);
            end
            OP_BNE: begin
                new_pc  = pc_in + br_off;
                taken_c = (cmp_a != cmp_b);
            end
            OP_JAL: begin
                new_pc  = pc_in + jal_off;
                taken_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign jump = accept_c & taken_c;
`else
    logic unused_cmp_fwd;

    assign unused_cmp_fwd = ^{cmp_fwd_sel1, cmp_fwd_sel2, cmp_fwd_data};
    assign new_pc         = '0;
    assign jump           = 1'b0;
`endif

endmodule

// File: tb/tb_decode_pipe_unit.sv
// tb_decode_pipe_unit: directed scenarios followed by randomized traffic, all
// checked against a table/array reference model of the decode stage.
module tb_decode_pipe_unit;

    localparam int unsigned XLEN      = 16;
    localparam int unsigned IMM_SCALE = 1;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pc_in;
    logic [15:0] ir_in;
    logic        rf_write;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        cmp_fwd_sel1, cmp_fwd_sel2;
    logic [15:0] cmp_fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        RegWrite, ALUSrc, MemWrite, MemRead;
    logic [2:0]  ALUOp;
    logic [1:0]  RegStore;
    logic [3:0]  funct;
    logic [15:0] Arg1, Arg2, Arg3, Imm, OPCP2, new_pc;
    logic [2:0]  Rs1, Rs2, Rd;
    logic        jump;

    decode_pipe_unit #(.XLEN(XLEN), .IMM_SCALE(IMM_SCALE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .ir_in(ir_in), .rf_write(rf_write), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .cmp_fwd_sel1(cmp_fwd_sel1), .cmp_fwd_sel2(cmp_fwd_sel2),
        .cmp_fwd_data(cmp_fwd_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
        .MemRead(MemRead), .ALUOp(ALUOp), .RegStore(RegStore), .funct(funct),
        .Arg1(Arg1), .Arg2(Arg2), .Arg3(Arg3), .Imm(Imm), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .OPCP2(OPCP2), .new_pc(new_pc), .jump(jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_check;
    int n_pass;
    int n_fail;

    // Reference model: register array plus the expected ID/EX contents.
    // Control vector layout: {RegWrite, ALUSrc, ALUOp[2:0], MemWrite, MemRead, RegStore[1:0]}.
    logic [15:0] m_regs [8];
    logic [8:0]  ctrl_tbl [8];
    logic        m_valid;
    logic [8:0]  m_ctrl;
    logic [3:0]  m_funct;
    logic [15:0] m_arg1, m_arg2, m_arg3, m_imm, m_opcp2;
    logic [2:0]  m_rs1, m_rs2, m_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
        if (rf_write && (rf_waddr == a)) return rf_wdata;
        return m_regs[a];
    endfunction

    task automatic m_clear_pipe();
        m_valid = 1'b0; m_ctrl = '0; m_funct = '0;
        m_arg1 = '0; m_arg2 = '0; m_arg3 = '0; m_imm = '0; m_opcp2 = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    endtask

    task automatic m_clear_all();
        m_clear_pipe();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    endtask

    task automatic chk_regs();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("ctrl", 64'({RegWrite, ALUSrc, ALUOp, MemWrite, MemRead, RegStore}), 64'(m_ctrl));
        chk("funct", 64'(funct), 64'(m_funct));
        chk("Arg1", 64'(Arg1), 64'(m_arg1));
        chk("Arg2", 64'(Arg2), 64'(m_arg2));
        chk("Arg3", 64'(Arg3), 64'(m_arg3));
        chk("Imm", 64'(Imm), 64'(m_imm));
        chk("regidx", 64'({Rs1, Rs2, Rd}), 64'({m_rs1, m_rs2, m_rd}));
        chk("OPCP2", 64'(OPCP2), 64'(m_opcp2));
    endtask

    // One clock: check combinational outputs, advance model and DUT, check registers.
    task automatic tick();
        logic [2:0]  op, rd, rs1, rs2;
        logic        lu, rdy, acc, exp_jump;
        logic [15:0] exp_npc;
`ifdef DECODE_BRANCH_RESOLVE_EN
        logic [15:0] a, b;
        int          off;
`endif
        #1;
        op  = ir_in[2:0];
        rd  = ir_in[5:3];
        rs1 = ir_in[8:6];
        rs2 = ir_in[11:9];
        lu  = m_valid && m_ctrl[2] && (m_rd != 3'd0) &&
              ((m_rd == rs1) || (m_rd == rs2) || ((op inside {3'd3, 3'd4, 3'd5}) && (m_rd == rd)));
        rdy = !reset && !flush && (!m_valid || out_ready) && !lu;
        acc = in_valid && rdy;
        exp_jump = 1'b0;
        exp_npc  = 16'h0;
`ifdef DECODE_BRANCH_RESOLVE_EN
        a = cmp_fwd_sel1 ? cmp_fwd_data : m_read(rs1);
        b = cmp_fwd_sel2 ? cmp_fwd_data : m_read(rd);
        if (op == 3'd4 || op == 3'd5) begin
            off      = sext(int'(ir_in[15:9]), 7) * (1 << IMM_SCALE);
            exp_npc  = pc_in + 16'(off);
            exp_jump = acc && ((op == 3'd4) ? (a == b) : (a != b));
        end else if (op == 3'd6) begin
            off      = sext(int'(ir_in[15:6]), 10) * (1 << IMM_SCALE);
            exp_npc  = pc_in + 16'(off);
            exp_jump = acc;
        end
`endif
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("jump", 64'(jump), 64'(exp_jump));
        chk("new_pc", 64'(new_pc), 64'(exp_npc));

        if (reset) begin
            m_clear_all();
        end else begin
            if (flush) begin
                m_clear_pipe();
            end else if (acc) begin
                m_valid = 1'b1;
                m_ctrl  = ctrl_tbl[op];
                m_funct = ir_in[15:12];
                m_arg1  = m_read(rs1);
                m_arg2  = m_read(rs2);
                m_arg3  = m_read(rd);
                m_imm   = 16'(sext(int'(ir_in[15:9]), 7));
                m_rs1   = rs1;
                m_rs2   = rs2;
                m_rd    = rd;
                m_opcp2 = pc_in + 16'd2;
            end else if (out_ready) begin
                m_clear_pipe();
            end
            if (rf_write && (rf_waddr != 3'd0)) m_regs[rf_waddr] = rf_wdata;
        end
        @(posedge clk);
        #1;
        chk_regs();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        in_valid = 1'b0; rf_write = 1'b1; rf_waddr = a; rf_wdata = d;
        tick();
        rf_write = 1'b0;
    endtask

    task automatic issue(input logic [15:0] pc, input logic [15:0] ir);
        in_valid = 1'b1; pc_in = pc; ir_in = ir;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_check = 0; n_pass = 0; n_fail = 0;
        ctrl_tbl = '{9'b1_1_010_0_0_01, 9'b1_0_001_0_0_01, 9'b1_0_001_0_1_00, 9'b0_0_001_1_0_00,
                     9'b0, 9'b0, 9'b1_0_000_0_0_10, 9'b0};
        reset = 1'b1; in_valid = 1'b0; pc_in = '0; ir_in = 16'h0007;
        rf_write = 1'b0; rf_waddr = '0; rf_wdata = '0;
        cmp_fwd_sel1 = 1'b0; cmp_fwd_sel2 = 1'b0; cmp_fwd_data = '0;
        flush = 1'b0; out_ready = 1'b1;
        m_clear_all();

        // Reset state
        @(posedge clk);
        #1;
        chk_regs();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset = 1'b0;

        // R/I/load/store decode
        wr(3'd5, 16'd16);
        wr(3'd6, 16'd10);
        wr(3'd4, 16'hFFF8);
        issue(16'h0100, 16'h1D60);
        chk("R_ctrl", 64'({RegWrite, ALUSrc, ALUOp, MemWrite, MemRead, RegStore}), 64'(9'b1_1_010_0_0_01));
        chk("R_args", 64'({Arg1, Arg2, Arg3}), 64'({16'd16, 16'd10, 16'hFFF8}));
        chk("R_idx", 64'({Rs1, Rs2, Rd}), 64'({3'd5, 3'd6, 3'd4}));
        chk("R_opcp2", 64'(OPCP2), 64'h0102);
        issue(16'h0102, 16'h1961);
        chk("I_imm", 64'({Imm, ALUSrc, ALUOp}), 64'({16'd12, 1'b0, 3'b001}));
        issue(16'h0104, 16'h1562);
        chk("L_memread", 64'({MemRead, Imm}), 64'({1'b1, 16'd10}));
        tick();
        issue(16'h0106, 16'h1563);
        chk("S_memwrite", 64'({MemWrite, RegWrite}), 64'({1'b1, 1'b0}));
        tick();

        // Load-use: one stall cycle, one bubble, then the dependent issues
        issue(16'h0110, 16'h0022);
        in_valid = 1'b1; pc_in = 16'h0112; ir_in = 16'h0508;
        #1;
        chk("lu_stall_ready", 64'(in_ready), 64'd0);
        tick();
        chk("lu_bubble", 64'(out_valid), 64'd0);
        tick();
        chk("lu_issue", 64'({out_valid, Rs1}), 64'({1'b1, 3'd4}));
        in_valid = 1'b0;

        // Write-through and x0
        in_valid = 1'b1; pc_in = 16'h0120; ir_in = 16'h00C0;
        rf_write = 1'b1; rf_waddr = 3'd3; rf_wdata = 16'd7;
        tick();
        chk("wt_arg1", 64'(Arg1), 64'd7);
        ir_in = 16'h0000; rf_waddr = 3'd0; rf_wdata = 16'd5;
        tick();
        rf_write = 1'b0;
        tick();
        chk("x0_args", 64'({Arg1, Arg2}), 64'd0);
        in_valid = 1'b0;

        // Branch resolution (x5 == x6, BEQ, pc 0x20, imm 4)
        wr(3'd6, 16'd16);
        in_valid = 1'b1; pc_in = 16'h0020; ir_in = 16'h0974;
        #1;
`ifdef DECODE_BRANCH_RESOLVE_EN
        chk("beq_taken", 64'({jump, new_pc}), 64'({1'b1, 16'h0028}));
`else
        chk("beq_off", 64'({jump, new_pc}), 64'd0);
`endif
        cmp_fwd_sel1 = 1'b1; cmp_fwd_data = 16'd99;
        #1;
        chk("beq_fwd_ne", 64'(jump), 64'd0);
        tick();
        cmp_fwd_sel1 = 1'b0;
        in_valid = 1'b0;
        tick();

        // Stall three cycles, then flush
        issue(16'h0200, 16'h1D60);
        out_ready = 1'b0; in_valid = 1'b1; ir_in = 16'h1961;
        tick(); tick(); tick();
        chk("stall_hold", 64'({out_valid, Arg1, OPCP2}), 64'({1'b1, 16'd16, 16'h0202}));
        flush = 1'b1; pc_in = 16'h0020; ir_in = 16'h0974;
        #1;
        chk("flush_jump", 64'({jump, in_ready}), 64'd0);
        tick();
        chk("flush_empty", 64'(out_valid), 64'd0);
        flush = 1'b0;

        // Reset while stalled
        out_ready = 1'b1;
        issue(16'h0300, 16'h1D60);
        out_ready = 1'b0; in_valid = 1'b1; ir_in = 16'h1961;
        tick(); tick();
        reset = 1'b1;
        #1;
        m_clear_all();
        chk_regs();
        tick();
        reset = 1'b0; out_ready = 1'b1;
        issue(16'h0400, 16'h1961);
        chk("post_rst_accept", 64'(out_valid), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            ir_in        = 16'($urandom);
            pc_in        = 16'($urandom) & 16'hFFFE;
            out_ready    = ($urandom_range(0, 3) != 0);
            rf_write     = ($urandom_range(0, 1) == 1);
            rf_waddr     = 3'($urandom);
            rf_wdata     = 16'($urandom_range(0, 3));
            flush        = ($urandom_range(0, 15) == 0);
            cmp_fwd_sel1 = ($urandom_range(0, 3) == 0);
            cmp_fwd_sel2 = ($urandom_range(0, 3) == 0);
            cmp_fwd_data = 16'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
